// File: rtl/ecc_secded_pipe.sv
// Two-stage Hamming SECDED decoder with valid/ready backpressure and saturating error counters.
// Optional ECC_SCRUB_EN adds out_ecc: re-encoded check bits of the corrected word for scrub write-back.
module ecc_secded_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int HAM_WIDTH  = 6,
  parameter int ECC_WIDTH  = HAM_WIDTH + 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ECC_WIDTH-1:0]  in_ecc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HAM_WIDTH-1:0]  out_syndrome,
  output logic                  out_err_corr,
  output logic                  out_err_dbl,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  cnt_corr,
  output logic [CNT_WIDTH-1:0]  cnt_dbl
`ifdef ECC_SCRUB_EN
  ,
  output logic [ECC_WIDTH-1:0]  out_ecc
`endif
);

  localparam int STAGES = 2;
  localparam int N      = DATA_WIDTH + HAM_WIDTH;
  localparam logic [HAM_WIDTH-1:0] N_POS = HAM_WIDTH'(N);

  // Codeword position of data bit j: the j-th non-power-of-2 position.
  function automatic int data_pos(input int j);
    int k;
    int p;
    k = 0;
    p = 0;
    for (int q = 1; q <= N; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (k == j) p = q;
        k++;
      end
    end
    return p;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ham_mask(input int i);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      if (((data_pos(j) >> i) & 1) != 0) m = m | (DATA_WIDTH'(1) << j);
    end
    return m;
  endfunction

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [HAM_WIDTH-1:0]  syn;
    logic                  q;
  } s1_t;

  logic [STAGES:1]       vld_pipe;
  logic                  adv;
  s1_t                   s1, s1_d;
  logic [HAM_WIDTH-1:0]  in_ham;
  logic [DATA_WIDTH-1:0] flip, fix_data;
  logic                  syn_zero, syn_bad, cls_corr, cls_dbl, out_hs;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_hs    = out_valid && out_ready;

  for (genvar i = 0; i < HAM_WIDTH; i++) begin : g_chk
    localparam logic [DATA_WIDTH-1:0] MASK = ham_mask(i);
    assign in_ham[i] = ^(in_data & MASK);
  end

  // A flip only lands on a data position; check-bit positions never match.
  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_fix
    localparam logic [HAM_WIDTH-1:0] POS = HAM_WIDTH'(data_pos(j));
    assign flip[j] = s1.q && (s1.syn == POS);
  end

  always_comb begin
    s1_d      = '0;
    s1_d.data = in_data;
    s1_d.syn  = in_ham ^ in_ecc[HAM_WIDTH-1:0];
    s1_d.q    = ^{in_data, in_ecc};
  end

  assign fix_data = s1.data ^ flip;
  assign syn_zero = (s1.syn == '0);
  assign syn_bad  = (s1.syn > N_POS);
  assign cls_corr = s1.q && !syn_bad;
  assign cls_dbl  = (s1.q && syn_bad) || (!s1.q && !syn_zero);

`ifdef ECC_SCRUB_EN
  logic [HAM_WIDTH-1:0] fix_ham;
  for (genvar i = 0; i < HAM_WIDTH; i++) begin : g_scrub
    localparam logic [DATA_WIDTH-1:0] MASK = ham_mask(i);
    assign fix_ham[i] = ^(fix_data & MASK);
  end

  always_ff @(posedge clk) begin
    if (rst)      out_ecc <= '0;
    else if (adv) out_ecc <= {^{fix_data, fix_ham}, fix_ham};
  end
`endif

  // Both stages advance together; bubbles travel through like words.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe     <= '0;
      s1           <= '0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_err_corr <= 1'b0;
      out_err_dbl  <= 1'b0;
    end else if (adv) begin
      vld_pipe     <= {vld_pipe[STAGES-1:1], in_valid};
      s1           <= s1_d;
      out_data     <= fix_data;
      out_syndrome <= s1.syn;
      out_err_corr <= cls_corr;
      out_err_dbl  <= cls_dbl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_corr <= '0;
      cnt_dbl  <= '0;
    end else if (out_hs) begin
      if (out_err_corr && (cnt_corr != '1)) cnt_corr <= cnt_corr + 1'b1;
      if (out_err_dbl  && (cnt_dbl  != '1)) cnt_dbl  <= cnt_dbl + 1'b1;
    end
  end

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Bench for ecc_secded_pipe: vector table streamed through a scoreboard, plus latency,
// stall, counter saturation/clear and mid-flight reset sequences.
module tb_ecc_secded_pipe;
  localparam int DW = 32;
  localparam int HW = 6;
  localparam int EW = 7;
  localparam int CW = 2;
  localparam int NV = 24;

  logic          clk;
  logic          rst, in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [DW-1:0] in_data, out_data;
  logic [EW-1:0] in_ecc;
  logic [HW-1:0] out_syndrome;
  logic          out_err_corr, out_err_dbl;
  logic [CW-1:0] cnt_corr, cnt_dbl;
`ifdef ECC_SCRUB_EN
  logic [EW-1:0] out_ecc;
`endif

  ecc_secded_pipe #(.DATA_WIDTH(DW), .HAM_WIDTH(HW), .ECC_WIDTH(EW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ecc(in_ecc), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syndrome(out_syndrome), .out_err_corr(out_err_corr),
    .out_err_dbl(out_err_dbl), .cnt_clr(cnt_clr), .cnt_corr(cnt_corr), .cnt_dbl(cnt_dbl)
`ifdef ECC_SCRUB_EN
    , .out_ecc(out_ecc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    logic [DW-1:0] xd;
    logic [HW-1:0] xs;
    logic          xc;
    logic          xb;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [HW-1:0] s;
    logic          c;
    logic          b;
    logic [EW-1:0] e;
  } exp_t;

  vec_t          tbl [NV];
  exp_t          sb [$];
  exp_t          cur_exp;
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] m_corr, m_dbl;
  logic          last_acc;

  // Walk positions upward, skipping powers of two, until the j-th data slot.
  function automatic int dpos(input int j);
    int pos = 2;
    int cnt = -1;
    while (cnt < j) begin
      pos++;
      if ((pos & (pos - 1)) != 0) cnt++;
    end
    return pos;
  endfunction

  // Check bits as the XOR of the positions of all set data bits.
  function automatic logic [EW-1:0] enc(input logic [DW-1:0] d);
    logic [HW-1:0] h = '0;
    for (int j = 0; j < DW; j++)
      if (((d >> j) & 32'h1) != 0) h = h ^ HW'(dpos(j));
    return {^d ^ ^h, h};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input vec_t v);
    in_data = v.d;
    in_ecc  = v.e;
    cur_exp = '{d: v.xd, s: v.xs, c: v.xc, b: v.xb, e: enc(v.xd)};
  endtask

  // One cycle: inputs already driven; checks mid-cycle, then waits to the next negedge.
  task automatic tick();
    exp_t x;
    logic hs;
    #1;
    hs = 1'b0;
    last_acc = 1'b0;
    x = '{default: '0};
    if (rst) begin
      sb.delete();
      m_corr = '0;
      m_dbl  = '0;
    end else begin
      chk("cnt_corr", 64'(cnt_corr), 64'(m_corr));
      chk("cnt_dbl", 64'(cnt_dbl), 64'(m_dbl));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 64'(1), 64'(0));
        else begin
          x  = sb.pop_front();
          hs = 1'b1;
          chk("out_data", 64'(out_data), 64'(x.d));
          chk("out_syndrome", 64'(out_syndrome), 64'(x.s));
          chk("out_err_corr", 64'(out_err_corr), 64'(x.c));
          chk("out_err_dbl", 64'(out_err_dbl), 64'(x.b));
`ifdef ECC_SCRUB_EN
          chk("out_ecc", 64'(out_ecc), 64'(x.e));
`endif
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        last_acc = 1'b1;
      end
      if (cnt_clr) begin
        m_corr = '0;
        m_dbl  = '0;
      end else if (hs) begin
        if (x.c && m_corr != '1) m_corr = m_corr + 1'b1;
        if (x.b && m_dbl != '1)  m_dbl  = m_dbl + 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int max);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < max && sb.size() > 0; i++) tick();
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    // Hand-computed vectors, including s==N and s==N+1 boundaries.
    tbl[0] = '{32'h0,         7'h00, 32'h0,         6'd0,  1'b0, 1'b0};
    tbl[1] = '{32'h1,         7'h00, 32'h0,         6'd3,  1'b1, 1'b0};
    tbl[2] = '{32'h0,         7'h40, 32'h0,         6'd0,  1'b1, 1'b0};
    tbl[3] = '{32'h3,         7'h00, 32'h3,         6'd6,  1'b0, 1'b1};
    tbl[4] = '{32'h8000_0000, 7'h09, 32'h8000_0000, 6'd47, 1'b0, 1'b1};
    tbl[5] = '{32'h0,         7'h04, 32'h0,         6'd4,  1'b1, 1'b0};
    tbl[6] = '{32'h8000_0000, 7'h26, 32'h8000_0000, 6'd0,  1'b0, 1'b0};
    tbl[7] = '{32'h8000_0000, 7'h00, 32'h0,         6'd38, 1'b1, 1'b0};
    tbl[8] = '{32'h0,         7'h67, 32'h0,         6'd39, 1'b0, 1'b1};
    for (int k = 9; k < NV; k++) begin
      logic [DW-1:0] d;
      logic [EW-1:0] e;
      int j1, j2, hb;
      d  = $urandom;
      e  = enc(d);
      j1 = $urandom_range(0, DW - 1);
      j2 = (j1 + 1 + $urandom_range(0, DW - 2)) % DW;
      hb = $urandom_range(0, HW - 1);
      case (k % 5)
        0: tbl[k] = '{d, e, d, 6'd0, 1'b0, 1'b0};
        1: tbl[k] = '{d ^ (32'h1 << j1), e, d, HW'(dpos(j1)), 1'b1, 1'b0};
        2: tbl[k] = '{d ^ (32'h1 << j1) ^ (32'h1 << j2), e,
                      d ^ (32'h1 << j1) ^ (32'h1 << j2), HW'(dpos(j1) ^ dpos(j2)), 1'b0, 1'b1};
        3: tbl[k] = '{d, e ^ (7'h1 << hb), d, 6'h1 << hb, 1'b1, 1'b0};
        default: tbl[k] = '{d, e ^ 7'h40, d, 6'd0, 1'b1, 1'b0};
      endcase
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_data = '0; in_ecc = '0; cur_exp = '{default: '0};
    m_corr = '0; m_dbl = '0; last_acc = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_syndrome", 64'(out_syndrome), 64'(0));
    chk("rst_flags", 64'({out_err_corr, out_err_dbl}), 64'(0));
    chk("rst_counters", 64'({cnt_corr, cnt_dbl}), 64'(0));

    // Two-cycle latency.
    set_vec(tbl[1]);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_cycle1", 64'(out_valid), 64'(0));
    tick();
    chk("lat_cycle2", 64'(out_valid), 64'(1));
    tick();

    // Table stream with random bubbles and backpressure.
    begin
      int idx = 0;
      for (int n = 0; n < 3000 && (idx < NV || sb.size() > 0); n++) begin
        in_valid  = (idx < NV) && ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        if (idx < NV) set_vec(tbl[idx]);
        tick();
        if (last_acc) idx++;
      end
      chk("stream_all_sent", 64'(idx), 64'(NV));
      if (sb.size() != 0) chk("stream_timeout", 64'(sb.size()), 64'(0));
    end

    // Stall: valid output held three cycles under out_ready=0.
    drain(20);
    set_vec(tbl[3]);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("stall_valid", 64'(out_valid), 64'(1));
    set_vec(tbl[1]);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
      chk("stall_out_data", 64'(out_data), 64'(tbl[3].xd));
      chk("stall_syndrome", 64'(out_syndrome), 64'(tbl[3].xs));
      chk("stall_err_dbl", 64'(out_err_dbl), 64'(1));
      tick();
    end
    drain(20);

    // Saturation: clear, then five corrected words on a 2-bit counter.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    set_vec(tbl[1]);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    drain(20);
    chk("cnt_saturate", 64'(cnt_corr), 64'(3));

    // Reset with words in flight: nothing emerges, nothing counted.
    set_vec(tbl[3]);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_counters", 64'({cnt_corr, cnt_dbl}), 64'(0));
    for (int k = 0; k < 4; k++) tick();

    // cnt_clr wins over a counted handshake.
    set_vec(tbl[2]);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_clr_count", 64'(cnt_corr), 64'(1));
    chk("pre_clr_valid", 64'(out_valid), 64'(1));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_wins", 64'(cnt_corr), 64'(0));

    drain(20);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecc_secded_pipe.md
Name: ecc_secded_pipe

Overview:
- Parametrised, pipelined Hamming SECDED decoder for memory read paths. It is the sequential successor of the combinational single-error-correcting ECC block.
- Adds double-error detection (extra overall-parity bit), a valid/ready handshake with backpressure, registered syndrome/status outputs and saturating error counters.
- Sits between memory read data and the consumer; the same check-bit equations are used by the write-side encoder.

Parameters:
- DATA_WIDTH, 32, data bits per word (≥4).
- HAM_WIDTH, 6, Hamming check bits r. Must satisfy 2^r ≥ DATA_WIDTH+r+1.
- ECC_WIDTH, HAM_WIDTH+1, total check bits; the MSB is overall parity.
- CNT_WIDTH, 16, width of each error counter.

Ports:
- clk  in  1  clock. Everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_WIDTH  received data.
- in_ecc  in  ECC_WIDTH  received check bits: [HAM_WIDTH-1:0] Hamming, [HAM_WIDTH] overall parity.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output.
- out_data  out  DATA_WIDTH  corrected data.
- out_syndrome  out  HAM_WIDTH  registered syndrome.
- out_err_corr  out  1  single error corrected. Also set for an overall-parity-bit-only error.
- out_err_dbl  out  1  uncorrectable error: double error, or invalid syndrome.
- cnt_clr  in  1  clears both counters.
- cnt_corr  out  CNT_WIDTH  count of corrected words, saturating.
- cnt_dbl  out  CNT_WIDTH  count of uncorrectable words, saturating.

Behaviour:
- Codeword positions run 1..N, with N = DATA_WIDTH+HAM_WIDTH.
  - Position 2^i holds check bit i.
  - Data bits fill the non-power-of-2 positions in ascending order: data[0] at position 3, data[1] at 5, data[2] at 6, ...
  - For 32 bits, data[31] is at position 38.
- Check bit i = XOR of all data bits whose position has bit i set.
- Overall parity = XOR of all data bits and all Hamming check bits.
- Stage 1 (registered):
  - s = recomputed Hamming bits XOR in_ecc[HAM_WIDTH-1:0].
  - q = XOR of in_data and all of in_ecc.
  - Data is registered alongside.
- Stage 2 (registered), classification:
  - q=0, s=0: clean. Data passes unchanged.
  - q=1, s=0: error in the overall parity bit. err_corr=1, data unchanged.
  - q=1, 1≤s≤N: single error. Flip the data bit at position s if s is a data position; if s is a power of 2, data is unchanged. err_corr=1.
  - q=1, s>N: uncorrectable. err_dbl=1, data passes uncorrected.
  - q=0, s≠0: double error. err_dbl=1, data passes uncorrected.
  - err_corr and err_dbl are never both 1.
- Latency is 2 cycles from the input handshake to out_valid, with no stall.
- Handshake and stall:
  - adv = !out_valid || out_ready, and in_ready = adv.
  - When adv=1, both stages load together and stage valid bits shift.
  - When adv=0, all pipeline registers hold and outputs stay stable.
  - Bubbles are not collapsed.
- out_syndrome holds s of the word currently on the output.
- Counters:
  - Update only on an output handshake (out_valid && out_ready): cnt_corr += err_corr, cnt_dbl += err_dbl.
  - Counters saturate at all-ones.
  - If cnt_clr and an increment occur in the same cycle, cnt_clr wins and the result is 0.
- Reset:
  - Clears both stage valids, out_valid, out_data, out_syndrome, both error flags and both counters to 0.
  - in_ready is 1 in the cycle after reset is released.
  - Reset mid-operation discards in-flight words without counting them.

Optional Feature:
- Macro: ECC_SCRUB_EN.
- Defined: adds output out_ecc [ECC_WIDTH-1:0], registered in stage 2 alongside out_data. It holds freshly encoded check bits of the corrected data, for scrub write-back. Reset value is 0. It holds under stall like the other outputs.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan (DATA_WIDTH=32):
- Clean word: in_data=0, in_ecc=0, out_ready=1 -> 2 cycles later out_data=0, syndrome=0, both flags 0, counters unchanged.
- Single-bit flip: in_data=32'h1 (data[0] flipped), in_ecc=0 -> out_data=0, syndrome=3, err_corr=1, cnt_corr=1.
- Overall-parity-bit flip: in_data=0, in_ecc=7'h40 -> out_data=0, syndrome=0, err_corr=1.
- Double error: in_data=32'h3, in_ecc=0 -> syndrome=6, err_dbl=1, out_data=32'h3, cnt_dbl=1.
- Invalid syndrome: in_data=32'h8000_0000, in_ecc=7'h09 -> s=47 (>38), q=1 -> err_dbl=1, data uncorrected.
- Backpressure and counters:
  - Hold out_ready=0 for 3 cycles with a valid output -> in_ready=0, outputs stable, no counter change.
  - With CNT_WIDTH=2, 5 corrected words -> cnt_corr=3.
  - cnt_clr asserted together with a counted handshake -> cnt_corr=0.
